// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch block.
package fetch_pkg;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned INSN_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] insn;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous prefetch FIFO of fetch_entry_t; head is zero when empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           wr_data,
  output logic [$clog2(DEPTH):0] count,
  output fetch_entry_t           head
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t mem_q [DEPTH];
  fetch_entry_t mem_d [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Power-of-2 depth lets the pointers wrap by natural overflow.
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[wptr_q] = wr_data;
        wptr_d        = wptr_q + PTR_W'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q   <= '{default: '0};
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign head  = (count_q != '0) ? mem_q[rptr_q] : '0;
endmodule

// File: rtl/insn_fetch_ctrl.sv
// Fetch sequencer: owns the PC, feeds a prefetch FIFO, handles redirect/halt.
// Optional FETCH_BOUND_CHECK_EN enables the sticky out-of-range fetch_fault.
module insn_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned MEM_WORDS = 201
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_insn,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_insn,
  output logic [31:0] if_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        fetch_fault
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

`ifdef FETCH_BOUND_CHECK_EN
  localparam bit BOUND_EN = 1'b1;
`else
  localparam bit BOUND_EN = 1'b0;
`endif

  logic [XLEN-1:0]  pc_q, pc_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] count;
  fetch_entry_t     head;
  fetch_entry_t     wr_entry;
  logic             valid_c, pop_c, push_c, oob_c;

  assign valid_c = (count != '0);
  assign oob_c   = BOUND_EN && ({2'b00, pc_q[31:2]} >= MEM_WORDS);
  assign pop_c   = valid_c & if_ready & ~redirect_valid;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign push_c  = ~rst & ~redirect_valid & ~halt & ~oob_c &
                   ((count < CNT_W'(DEPTH)) | pop_c);

  assign wr_entry.insn = imem_insn;
  assign wr_entry.pc   = pc_q;

  always_comb begin
    pc_d    = pc_q;
    fault_d = fault_q;
    if (redirect_valid) begin
      pc_d    = redirect_pc & ~XLEN'(INSN_BYTES - 1);
      fault_d = 1'b0;
    end else begin
      if (push_c) begin
        pc_d = pc_q + XLEN'(INSN_BYTES);
      end
      if (!halt && oob_c) begin
        fault_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_c),
    .pop     (pop_c),
    .flush   (redirect_valid),
    .wr_data (wr_entry),
    .count   (count),
    .head    (head)
  );

  assign imem_addr   = pc_q;
  assign if_valid    = valid_c;
  assign if_insn     = head.insn;
  assign if_pc       = head.pc;
  assign fetch_fault = fault_q;
endmodule

// File: tb/tb_insn_fetch_ctrl.sv
// Self-checking bench for insn_fetch_ctrl: queue-based reference model plus directed checks.
module tb_insn_fetch_ctrl;
  localparam int unsigned DEPTH     = 2;
  localparam int unsigned MEM_WORDS = 201;
`ifdef FETCH_BOUND_CHECK_EN
  localparam bit BOUND = 1'b1;
`else
  localparam bit BOUND = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_insn;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_insn;
  logic [31:0] if_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;
  bit model_en = 1'b0;

  insn_fetch_ctrl #(.RESET_PC(32'h0), .DEPTH(DEPTH), .MEM_WORDS(MEM_WORDS)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_insn      (imem_insn),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_insn        (if_insn),
    .if_pc          (if_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  // Instruction memory: word k holds 0x100 + k.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h100 + {22'b0, a[11:2]};
  endfunction

  assign imem_insn = mem_word(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of {insn, pc} and a model PC.
  logic [63:0] mq[$];
  logic [31:0] m_pc;
  logic        m_fault;

  always @(posedge clk) begin
    bit do_pop, do_push, oob;
    if (rst) begin
      mq.delete();
      m_pc    = 32'h0;
      m_fault = 1'b0;
      model_en = 1'b1;
    end else if (redirect_valid) begin
      mq.delete();
      m_pc    = redirect_pc & 32'hFFFF_FFFC;
      m_fault = 1'b0;
    end else begin
      oob     = BOUND && ((m_pc >> 2) >= MEM_WORDS);
      do_pop  = (mq.size() != 0) && if_ready;
      do_push = !halt && !oob && ((mq.size() < DEPTH) || do_pop);
      if (!halt && oob) m_fault = 1'b1;
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back({mem_word(m_pc), m_pc});
        m_pc = m_pc + 32'd4;
      end
    end
  end

  always @(negedge clk) begin
    if (model_en) begin
      chk("m_valid", {31'b0, if_valid}, {31'b0, mq.size() != 0});
      chk("m_pc",    if_pc,   (mq.size() != 0) ? mq[0][31:0]  : 32'h0);
      chk("m_insn",  if_insn, (mq.size() != 0) ? mq[0][63:32] : 32'h0);
      chk("m_addr",  imem_addr, m_pc);
      chk("m_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; if_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; halt = 1'b0;
    tick(2);
    chk("rst_valid", {31'b0, if_valid}, 32'h0);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_pc",    if_pc, 32'h0);
    chk("rst_insn",  if_insn, 32'h0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'h0);

    // Streaming with if_ready held high.
    rst = 1'b0; if_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("stream_pc",   if_pc, 32'(4 * i));
      chk("stream_insn", if_insn, 32'(32'h100 + i));
    end

    // Backpressure from a fresh reset.
    rst = 1'b1; tick(); rst = 1'b0; if_ready = 1'b0;
    tick(5);
    chk("bp_addr",  imem_addr, 32'h8);
    chk("bp_head",  if_pc, 32'h0);
    if_ready = 1'b1;
    tick(); chk("bp_seq4",  if_pc, 32'h4);
    tick(); chk("bp_seq8",  if_pc, 32'h8);
    tick(); chk("bp_seq12", if_pc, 32'hC);

    // Redirect with a valid head and ready asserted.
    redirect_valid = 1'b1; redirect_pc = 32'h43;
    tick();
    chk("redir_valid", {31'b0, if_valid}, 32'h0);
    chk("redir_addr",  imem_addr, 32'h40);
    redirect_valid = 1'b0;
    tick();
    chk("redir_pc",   if_pc, 32'h40);
    chk("redir_insn", if_insn, 32'h110);

    // Halt with a full FIFO drains it and holds the PC.
    if_ready = 1'b0; tick(2);
    halt = 1'b1; if_ready = 1'b1;
    tick(); chk("halt_drain1", if_pc, 32'h44);
    tick(); chk("halt_empty", {31'b0, if_valid}, 32'h0);
    tick(2); chk("halt_addr", imem_addr, 32'h48);
    halt = 1'b0;
    tick(); chk("halt_resume", if_pc, 32'h48);

    // Redirect during halt still loads the PC; fetch waits for halt to drop.
    halt = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
    tick(); redirect_valid = 1'b0;
    chk("hredir_addr", imem_addr, 32'h80);
    tick(); chk("hredir_valid", {31'b0, if_valid}, 32'h0);
    halt = 1'b0;
    tick(); chk("hredir_pc", if_pc, 32'h80);

    // Reset mid-stream with a full FIFO.
    if_ready = 1'b0; tick(2);
    rst = 1'b1; tick();
    chk("mrst_valid", {31'b0, if_valid}, 32'h0);
    chk("mrst_addr",  imem_addr, 32'h0);
    rst = 1'b0; if_ready = 1'b1;
    tick(); chk("mrst_pc", if_pc, 32'h0);

    // Back-to-back redirects: the last one wins.
    redirect_valid = 1'b1; redirect_pc = 32'h100; tick();
    redirect_pc = 32'h206; tick();
    redirect_valid = 1'b0;
    tick();
    chk("b2b_pc",   if_pc, 32'h204);
    chk("b2b_insn", if_insn, 32'h181);

`ifdef FETCH_BOUND_CHECK_EN
    redirect_valid = 1'b1; redirect_pc = 32'h320; tick();
    redirect_valid = 1'b0;
    tick();
    chk("bnd_pc",   if_pc, 32'h320);
    chk("bnd_insn", if_insn, 32'h1C8);
    tick();
    chk("bnd_fault", {31'b0, fetch_fault}, 32'h1);
    chk("bnd_valid", {31'b0, if_valid}, 32'h0);
    chk("bnd_addr",  imem_addr, 32'h324);
    tick();
    chk("bnd_sticky", {31'b0, fetch_fault}, 32'h1);
    redirect_valid = 1'b1; redirect_pc = 32'h0; tick();
    redirect_valid = 1'b0;
    chk("bnd_clear", {31'b0, fetch_fault}, 32'h0);
    tick(); chk("bnd_after", if_pc, 32'h0);
`else
    // PC wraps modulo 2^32; out-of-range words are fetched as-is.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; tick();
    redirect_valid = 1'b0;
    tick();
    chk("wrap_pc",   if_pc, 32'hFFFF_FFFC);
    chk("wrap_insn", if_insn, 32'h4FF);
    tick();
    chk("wrap_next", if_pc, 32'h0);
    chk("wrap_fault", {31'b0, fetch_fault}, 32'h0);
`endif

    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/insn_fetch_ctrl.md
Name: insn_fetch_ctrl

Overview:
- Instruction-fetch sequencer that owns the PC and drives the address of the combinational-read instruction memory. The memory is word-indexed by address bits [11:2].
- Captures each returned word, tagged with its PC, into a small prefetch FIFO. Presents it to decode with a valid/ready handshake.
- Handles pipeline redirects (branch/jump/trap), which flush the FIFO, and a halt request.
- Sits between insn_mem and the decode stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- DEPTH, 2, prefetch FIFO entries; power of 2, minimum 2.
- MEM_WORDS, 201, number of valid instruction-memory words; used only by the optional feature.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_addr  out  32  byte address to insn_mem; equals fetch PC.
- imem_insn  in  32  word returned by insn_mem the same cycle.
- if_valid  out  1  FIFO head valid.
- if_ready  in  1  decode accepts head.
- if_insn  out  32  head instruction; 0 when if_valid=0.
- if_pc  out  32  head PC; 0 when if_valid=0.
- redirect_valid  in  1  load new PC and flush.
- redirect_pc  in  32  target PC; bits [1:0] are forced to 0.
- halt  in  1  suppress new fetches while high.
- fetch_fault  out  1  sticky out-of-range flag; constant 0 without the macro.

Behaviour:
- Reset (rst=1 at posedge):
  - pc_q=RESET_PC; FIFO count=0; read/write pointers=0; fetch_fault=0.
  - if_valid=0, if_insn=0, if_pc=0; imem_addr=RESET_PC.
- imem_addr=pc_q at all times (combinational from the register). imem_insn is sampled in the same cycle.
- pop = if_valid & if_ready & ~redirect_valid.
- push = ~rst & ~redirect_valid & ~halt & (count<DEPTH | pop).
  - Full with a simultaneous pop: the push is allowed and count is unchanged.
- On push: the entry {imem_insn, pc_q} is written at the write pointer, and pc_q <= pc_q+4. The PC wraps modulo 2^32 with no flag.
- Count: +1 on push only, -1 on pop only, unchanged on both or neither. Pointers wrap modulo DEPTH.
- Latency: a word pushed in cycle N is visible at if_valid/if_insn in cycle N+1 at the earliest.
- Throughput: with if_ready held at 1, one instruction per cycle is sustained.
- Head output: if_valid=(count!=0), registered-state driven. There is no combinational path from if_ready to if_valid.
- Redirect has highest priority after rst:
  - count<=0 and pc_q<={redirect_pc[31:2],2'b00}.
  - No push and no pop in that cycle; a concurrent if_ready is ignored.
  - if_valid=0 in cycle N+1, when the target word is pushed; the target is visible in cycle N+2.
  - Redirect while halt=1: the PC is still loaded and the FIFO is still flushed; fetching resumes when halt drops.
- Halt: fetches stop and pc_q holds. The FIFO keeps draining through the handshake.
- A reset asserted mid-stream discards all FIFO contents. There is no partial state.
- Back-to-back redirects: the last one wins, with the same per-cycle rule.

Optional Feature:
- Macro: FETCH_BOUND_CHECK_EN.
- Defined:
  - If pc_q[31:2] >= MEM_WORDS, push is suppressed and fetch_fault<=1.
  - fetch_fault is sticky and clears only on rst or redirect_valid.
  - The FIFO drains normally while fetch_fault=1.
- Undefined: no check is performed, fetch_fault is tied to 0, and out-of-range addresses are fetched as-is.

Decomposition:
- Package fetch_pkg:
  - XLEN=32, INSN_BYTES=4.
  - Typedef fetch_entry_t {insn[31:0], pc[31:0]}.
  - Constant RESET_PC_DEFAULT.
- One sub-module, fetch_fifo: a DEPTH-entry synchronous FIFO of fetch_entry_t with push, pop, flush, count, head.
- The top level holds the PC, push/pop/redirect priority logic and the fault logic.

Test Plan:
- Stream: after reset, with if_ready=1 and the memory holding word k=0x100+k:
  - Cycle 1: if_pc=0, if_insn=0x100.
  - Then if_pc advances 4 per cycle with no bubbles.
- Backpressure: with if_ready=0 for 5 cycles, count saturates at DEPTH=2 and imem_addr holds at 8. Then raise if_ready:
  - The sequence resumes 0, 4, 8 with no loss or duplicate.
- Redirect: redirect_pc=0x43 while if_valid=1 and if_ready=1:
  - Next cycle if_valid=0.
  - The cycle after: if_pc=0x40 with the word at index 16.
  - The old head is never popped twice.
- Halt: with halt=1 and a full FIFO, if_ready=1 drains 2 entries, then if_valid=0 and pc_q is unchanged. Drop halt:
  - The next if_pc equals the held PC.
- Reset mid-stream: rst for 1 cycle while count=2:
  - if_valid=0 and imem_addr=RESET_PC.
  - First post-reset if_pc=0.
- With FETCH_BOUND_CHECK_EN: redirect to 0x320 (word 200, the last valid):
  - One instruction is delivered.
  - At PC 0x324, fetch_fault=1 and no push occurs.
  - A redirect to 0 clears the fault.
